term_parser: RTL and testbench

Byte-stream terminal interpreter sitting directly downstream of the UART receiver. Consumes one received byte per `rx_complete` strobe, tracks a text cursor, and emits single-cell writes into the character RAM that the video scan-out reads. Handles printable ASCII, CR/LF/BS/TAB, hardware scrolling via a circular row base, and a minimal ANSI CSI subset (cursor position, clear screen, clear to end of line).

---
 rtl/term_pkg.sv | 38 +++
 rtl/term_fill.sv | 53 +++++
 rtl/term_parser.sv | 263 ++++++++++++++++++++++++++
 tb/tb_term_parser.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// term_pkg : character codes, parser state encoding and address helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package term_pkg;

  localparam int C_COLS_DEF = 80;
  localparam int C_ROWS_DEF = 30;
  localparam int C_ADDR_W   = 12;

  localparam logic [7:0] C_BS    = 8'h08;
  localparam logic [7:0] C_TAB   = 8'h09;
  localparam logic [7:0] C_LF    = 8'h0A;
  localparam logic [7:0] C_CR    = 8'h0D;
  localparam logic [7:0] C_ESC   = 8'h1B;
  localparam logic [7:0] C_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  // Width able to hold a cell count from 0 up to a full screen.
  function automatic int cnt_width(input int cols, input int rows);
    return $clog2(cols * rows + 1);
  endfunction

  function automatic logic [C_ADDR_W-1:0] cell_addr(input logic [4:0] prow,
                                                    input logic [6:0] col,
                                                    input int         cols);
    return C_ADDR_W'(prow) * C_ADDR_W'(cols) + C_ADDR_W'(col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/term_fill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// term_fill : writes a run of cells one per cycle, wrapping physical rows
// Rev 1.0
// ----------------------------------------------------------------------------
module term_fill
  import term_pkg::*;
#(
  parameter int COLS  = C_COLS_DEF,
  parameter int ROWS  = C_ROWS_DEF,
  parameter int CNT_W = cnt_width(C_COLS_DEF, C_ROWS_DEF)
) (
  input  logic                clk100,
  input  logic                rst,
  input  logic                start_i,
  input  logic [4:0]          row_i,
  input  logic [6:0]          col_i,
  input  logic [CNT_W-1:0]    count_i,
  output logic                busy_o,
  output logic                last_o,
  output logic [C_ADDR_W-1:0] addr_o
);

  logic [4:0]       row_q;
  logic [6:0]       col_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk100) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      row_q <= row_i;
      col_q <= col_i;
      cnt_q <= count_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      if (col_q == 7'(COLS - 1)) begin
        col_q <= '0;
        row_q <= (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      end else begin
        col_q <= col_q + 7'd1;
      end
    end
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == CNT_W'(1));
  assign addr_o = cell_addr(row_q, col_q, COLS);

endmodule
`default_nettype wire

// File: rtl/term_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// term_parser : UART byte-stream terminal interpreter driving character RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module term_parser
  import term_pkg::*;
#(
  parameter int COLS = C_COLS_DEF,
  parameter int ROWS = C_ROWS_DEF
) (
  input  logic                clk100,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_complete,
  output logic                wr_en,
  output logic [C_ADDR_W-1:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic [6:0]          cursor_col,
  output logic [4:0]          cursor_row,
  output logic [4:0]          top_row,
  output logic                busy,
  output logic                overflow
);

  localparam int         CNT_W      = cnt_width(COLS, ROWS);
  localparam logic [6:0] C_LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

  state_e              state_q, state_d;
  logic [6:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [4:0]          top_q, top_d;
  logic [7:0]          p0_q, p0_d, p1_q, p1_d;
  logic                idx_q, idx_d;
  logic                hold_vld_q, hold_vld_d;
  logic [7:0]          hold_q, hold_d;
  logic                ovf_q, ovf_d;
  logic                pend_q, pend_d;
  logic                we_q, we_d;
  logic [C_ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic                fill_start;
  logic [4:0]          fill_row;
  logic [6:0]          fill_col;
  logic [CNT_W-1:0]    fill_cnt;
  logic                fill_busy, fill_last;
  logic [C_ADDR_W-1:0] fill_addr;

  logic                proceed, take, nl, nl_defer;
  logic [7:0]          b, p_sel, p_sat, tab_col, h_row, h_col;
  logic [11:0]         p_mul;
  logic [5:0]          phys_sum;
  logic [4:0]          phys_row;

  term_fill #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_fill (
    .clk100  (clk100),
    .rst     (rst),
    .start_i (fill_start),
    .row_i   (fill_row),
    .col_i   (fill_col),
    .count_i (fill_cnt),
    .busy_o  (fill_busy),
    .last_o  (fill_last),
    .addr_o  (fill_addr)
  );

  assign phys_sum = {1'b0, top_q} + {1'b0, row_q};
  assign phys_row = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    idx_d      = idx_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    fill_start = 1'b0;
    fill_row   = phys_row;
    fill_col   = col_q;
    fill_cnt   = '0;
    nl         = 1'b0;
    nl_defer   = 1'b0;

    proceed = (state_q != ST_FILL) && !fill_busy;
    b       = hold_vld_q ? hold_q : rx_data;
    take    = proceed && (hold_vld_q || rx_complete);

    // A held byte and a fresh strobe can coexist only when the held one drains now.
    if (rx_complete) begin
      if (hold_vld_q && !proceed) begin
        ovf_d = 1'b1;
      end else if (hold_vld_q || !proceed) begin
        hold_vld_d = 1'b1;
        hold_d     = rx_data;
      end
    end else if (take) begin
      hold_vld_d = 1'b0;
    end

    p_sel   = idx_q ? p1_q : p0_q;
    p_mul   = 12'(p_sel) * 12'd10 + 12'(b - 8'h30);
    p_sat   = (p_mul > 12'd255) ? 8'hFF : p_mul[7:0];
    tab_col = {1'b0, col_q & 7'h78} + 8'd8;
    h_row   = (p0_q == 8'd0) ? 8'd0 : p0_q - 8'd1;
    h_col   = (p1_q == 8'd0) ? 8'd0 : p1_q - 8'd1;

    if (take) begin
      case (state_q)
        ST_IDLE: begin
          if (b >= 8'h20 && b <= 8'h7E) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(phys_row, col_q, COLS);
            wdata_d = b;
            if (col_q == C_LAST_COL) begin
              col_d    = '0;
              nl       = 1'b1;
              nl_defer = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (b)
              C_CR:  col_d = '0;
              C_BS:  if (col_q != '0) col_d = col_q - 7'd1;
              C_TAB: col_d = (tab_col > 8'(COLS - 1)) ? C_LAST_COL : tab_col[6:0];
              C_LF:  nl = 1'b1;
              C_ESC: state_d = ST_ESC;
              default: ;
            endcase
          end
        end
        ST_ESC: begin
          if (b == 8'h5B) begin
            state_d = ST_CSI;
            p0_d    = '0;
            p1_d    = '0;
            idx_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CSI: begin
          if (b >= 8'h30 && b <= 8'h39) begin
            if (idx_q) p1_d = p_sat;
            else       p0_d = p_sat;
          end else if (b == 8'h3B) begin
            idx_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            if (b == 8'h48 || b == 8'h66) begin
              row_d = (h_row > 8'(ROWS - 1)) ? C_LAST_ROW : h_row[4:0];
              col_d = (h_col > 8'(COLS - 1)) ? C_LAST_COL : h_col[6:0];
            end else if (b == 8'h4A && p0_q == 8'd2) begin
              top_d      = '0;
              row_d      = '0;
              col_d      = '0;
              state_d    = ST_FILL;
              fill_start = 1'b1;
              fill_row   = '0;
              fill_col   = '0;
              fill_cnt   = CNT_W'(COLS * ROWS);
            end else if (b == 8'h4B) begin
              state_d    = ST_FILL;
              fill_start = 1'b1;
              fill_cnt   = CNT_W'(COLS) - CNT_W'(col_q);
            end
          end
        end
        default: ;
      endcase
    end

    // A scroll caused by wrapping a printed character waits one cycle so the
    // character write and the first blank write never collide.
    if (nl) begin
      if (row_q != C_LAST_ROW) begin
        row_d = row_q + 5'd1;
      end else begin
        top_d   = (top_q == C_LAST_ROW) ? 5'd0 : top_q + 5'd1;
        state_d = ST_FILL;
        if (nl_defer) begin
          pend_d = 1'b1;
        end else begin
          fill_start = 1'b1;
          fill_row   = top_q;
          fill_col   = '0;
          fill_cnt   = CNT_W'(COLS);
        end
      end
    end

    if (state_q == ST_FILL) begin
      if (pend_q) begin
        pend_d     = 1'b0;
        fill_start = 1'b1;
        fill_row   = (top_q == 5'd0) ? C_LAST_ROW : top_q - 5'd1;
        fill_col   = '0;
        fill_cnt   = CNT_W'(COLS);
      end else if (fill_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
      idx_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      idx_q      <= idx_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign wr_en      = we_q | fill_busy;
  assign wr_addr    = fill_busy ? fill_addr : waddr_q;
  assign wr_data    = fill_busy ? C_SPACE : wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign top_row    = top_q;
  assign busy       = fill_busy;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_term_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_term_parser : scoreboard bench with a byte-level terminal reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_term_parser;
  import term_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_complete = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  top_row;
  logic        busy;
  logic        overflow;

  term_parser #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk100      (clk100),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_complete (rx_complete),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .top_row     (top_row),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk100 = ~clk100;

  int total = 0;
  int bad = 0;

  // Reference terminal: cursor, scroll offset, escape mode and CSI params.
  int m_r, m_c, m_top, m_mode, m_idx;
  int m_p[2];
  logic [19:0] exp_q[$];

  task automatic m_reset();
    m_r = 0; m_c = 0; m_top = 0; m_mode = 0; m_idx = 0;
    m_p[0] = 0; m_p[1] = 0;
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({12'(a), 8'(d)});
  endtask

  function automatic int maddr(input int r, input int c);
    return ((m_top + r) % ROWS) * COLS + c;
  endfunction

  task automatic m_newline();
    if (m_r < ROWS - 1) m_r++;
    else begin
      m_top = (m_top + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push(maddr(ROWS - 1, i), 32);
    end
  endtask

  task automatic m_byte(input logic [7:0] bb);
    int v, t;
    v = int'(bb);
    if (m_mode == 0) begin
      if (v >= 32 && v <= 126) begin
        push(maddr(m_r, m_c), v);
        m_c++;
        if (m_c == COLS) begin m_c = 0; m_newline(); end
      end else if (v == 13) m_c = 0;
      else if (v == 8) begin if (m_c > 0) m_c--; end
      else if (v == 9) begin
        t = (m_c / 8 + 1) * 8;
        m_c = (t > COLS - 1) ? COLS - 1 : t;
      end else if (v == 10) m_newline();
      else if (v == 27) m_mode = 1;
    end else if (m_mode == 1) begin
      if (v == 91) begin m_mode = 2; m_p[0] = 0; m_p[1] = 0; m_idx = 0; end
      else m_mode = 0;
    end else begin
      if (v >= 48 && v <= 57) begin
        t = m_p[m_idx] * 10 + (v - 48);
        m_p[m_idx] = (t > 255) ? 255 : t;
      end else if (v == 59) m_idx = 1;
      else begin
        m_mode = 0;
        if (v == 72 || v == 102) begin
          t = (m_p[0] < 1 ? 1 : m_p[0]) - 1;
          m_r = (t > ROWS - 1) ? ROWS - 1 : t;
          t = (m_p[1] < 1 ? 1 : m_p[1]) - 1;
          m_c = (t > COLS - 1) ? COLS - 1 : t;
        end else if (v == 74 && m_p[0] == 2) begin
          m_top = 0; m_r = 0; m_c = 0;
          for (int i = 0; i < COLS * ROWS; i++) push(i, 32);
        end else if (v == 75) begin
          for (int i = m_c; i < COLS; i++) push(maddr(m_r, i), 32);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk100) begin
    logic [19:0] e;
    if (!rst && wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic strobe(input logic [7:0] bb, input bit model);
    @(negedge clk100);
    rx_data = bb;
    rx_complete = 1'b1;
    if (model) m_byte(bb);
    @(negedge clk100);
    rx_complete = 1'b0;
  endtask

  task automatic wait_idle(output int bcyc);
    int n;
    bcyc = 0;
    n = 0;
    while ((n < 4 || busy) && n < 6000) begin
      if (busy) bcyc++;
      @(negedge clk100);
      n++;
    end
    if (n >= 6000) begin
      total++; bad++;
      $display("FAIL busy_timeout: got busy=%0d after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic send(input logic [7:0] bb, output int bcyc);
    strobe(bb, 1'b1);
    wait_idle(bcyc);
  endtask

  task automatic s(input logic [7:0] bb);
    int d;
    send(bb, d);
  endtask

  task automatic s_num(input int v);
    string str;
    str = $sformatf("%0d", v);
    for (int i = 0; i < str.len(); i++) s(str[i]);
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, int'(cursor_col), m_c);
    chk({tag, "_row"}, int'(cursor_row), m_r);
    chk({tag, "_top"}, int'(top_row), m_top);
  endtask

  initial begin
    int bc, sel, n;
    m_reset();
    repeat (3) @(negedge clk100);
    rst = 1'b0;
    chk("reset_outputs", int'({wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row, busy, overflow}), 0);

    s("A"); s("B");
    chk("ab_col", int'(cursor_col), 2);
    chk("ab_row", int'(cursor_row), 0);

    s(C_CR);
    for (int i = 0; i < COLS; i++) s("x");
    s("y");
    chk("wrap_col", int'(cursor_col), 1);
    chk("wrap_row", int'(cursor_row), 1);

    s(C_ESC); s("["); s("2"); send("J", bc);
    chk("clear_busy_cycles", bc, 2400);
    chk_cursor("clear");

    s(C_ESC); s("["); s_num(12); s(";"); s_num(40); s("H");
    s("Z");
    s(C_ESC); s("["); s_num(999); s(";"); s_num(999); s("H");
    chk("clamp_col", int'(cursor_col), 79);
    chk("clamp_row", int'(cursor_row), 29);

    send(C_LF, bc);
    chk("scroll_busy_cycles", bc, 80);
    chk("scroll_top", int'(top_row), 1);
    chk("scroll_row", int'(cursor_row), 29);

    s(C_ESC); s("["); s("1"); s(";"); s_num(70); send("f", bc);
    s(C_ESC); s("["); send("K", bc);
    chk("eol_busy_cycles", bc, 11);
    chk("eol_col", int'(cursor_col), 69);

    s(C_ESC); s("["); s_num(30); s(";"); s_num(80); s("H");
    send("W", bc);
    chk("wrap_scroll_busy_cycles", bc, 80);
    chk_cursor("wrap_scroll");

    s(C_TAB); s(C_TAB); s(C_BS); s(C_ESC); s("["); s("5"); s("J");
    chk_cursor("ctrl");
    chk("queue_drained_directed", exp_q.size(), 0);

    // Bytes arriving during a full-screen clear: first is held, second is lost.
    s(C_ESC); s("["); s("2"); strobe("J", 1'b1);
    repeat (20) @(negedge clk100);
    chk("midfill_busy", int'(busy), 1);
    strobe("Q", 1'b1);
    repeat (5) @(negedge clk100);
    chk("held_no_overflow", int'(overflow), 0);
    strobe("R", 1'b0);
    repeat (2) @(negedge clk100);
    chk("overflow_set", int'(overflow), 1);
    n = 0;
    while (busy && n < 5000) begin @(negedge clk100); n++; end
    chk("fill_ended", int'(busy), 0);
    repeat (4) @(negedge clk100);
    chk_cursor("held");
    chk("queue_drained_held", exp_q.size(), 0);

    // Reset in the middle of a clear stops writes immediately.
    s(C_ESC); s("["); s("2"); strobe("J", 1'b1);
    repeat (30) @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_outputs", int'({wr_en, wr_addr, wr_data, cursor_col, cursor_row, top_row, busy, overflow}), 0);
    rst = 1'b0;
    exp_q.delete();
    m_reset();
    repeat (3) @(negedge clk100);
    chk("post_rst_quiet", int'(wr_en), 0);

    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45) s(8'($urandom_range(32, 126)));
      else if (sel < 55) s(C_LF);
      else if (sel < 60) s(C_CR);
      else if (sel < 64) s(C_BS);
      else if (sel < 68) s(C_TAB);
      else if (sel < 80) begin
        s(C_ESC); s("[");
        if ($urandom_range(0, 3) != 0) s_num($urandom_range(0, 40));
        s(";");
        if ($urandom_range(0, 3) != 0) s_num($urandom_range(0, 300));
        s(($urandom_range(0, 1) != 0) ? 8'h48 : 8'h66);
      end else if (sel < 86) begin s(C_ESC); s("["); s("K"); end
      else if (sel < 88) begin s(C_ESC); s("["); s("2"); s("J"); end
      else if (sel < 92) begin s(C_ESC); s(8'($urandom_range(32, 126))); end
      else s(8'($urandom_range(0, 255)));
      chk_cursor("rand");
    end
    repeat (4) @(negedge clk100);
    chk("queue_drained_random", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
